// File: rtl/lbp_stream_engine.sv
`default_nettype none
// ============================================================================
// Module   : lbp_stream_engine
// Purpose  : Streaming 3x3 LBP over a 2^COL_W x 2^ROW_W grey image with window
//            reuse, tolerance, result backpressure and optional border fill.
// Revision : 1.0
// ============================================================================
module lbp_stream_engine #(
  parameter int COL_W = 7,
  parameter int ROW_W = 7,
  parameter int DW    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   gray_ready,
  output logic                   gray_req,
  output logic [ROW_W+COL_W-1:0] gray_addr,
  input  logic [DW-1:0]          gray_data,
  input  logic [DW-1:0]          tol,
  input  logic                   border_mode,
  output logic [ROW_W+COL_W-1:0] lbp_addr,
  output logic [7:0]             lbp_data,
  output logic                   lbp_valid,
  input  logic                   lbp_ready,
  output logic                   finish,
  output logic                   busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_SHIFT  = 3'd2,
    S_WRITE  = 3'd3,
    S_BORDER = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [ROW_W-1:0] C_ROW_LAST     = {ROW_W{1'b1}};
  localparam logic [COL_W-1:0] C_COL_LAST     = {COL_W{1'b1}};
  localparam logic [ROW_W-1:0] C_ROW_INT_LAST = C_ROW_LAST - ROW_W'(1);
  localparam logic [COL_W-1:0] C_COL_INT_LAST = C_COL_LAST - COL_W'(1);
  localparam bit               C_HAS_INT      = (COL_W >= 2) && (ROW_W >= 2);

  state_t            r_state, w_next;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [1:0]        r_sub;   // row offset inside the window column being fetched
  logic [1:0]        r_cofs;  // window column being fetched
  logic [DW-1:0]     r_win [0:8];  // column-major: index = col*3 + row
  logic [DW-1:0]     r_tol;
  logic              r_border;
  logic              r_gray_prev;

  logic              w_start, w_fetch_last, w_accept, w_col_more, w_row_more;
  logic              w_brd_edge_row, w_brd_last;
  logic [3:0]        w_win_idx;
  logic [ROW_W-1:0]  w_fetch_row;
  logic [COL_W-1:0]  w_fetch_col;
  logic [DW:0]       w_thresh;
  logic [7:0]        w_code;

  assign w_start        = gray_ready & ~r_gray_prev;
  assign w_fetch_last   = (r_cofs == 2'd2) && (r_sub == 2'd2);
  assign w_accept       = ((r_state == S_WRITE) || (r_state == S_BORDER)) && lbp_ready;
  assign w_col_more     = r_col < C_COL_INT_LAST;
  assign w_row_more     = r_row < C_ROW_INT_LAST;
  assign w_brd_edge_row = (r_row == '0) || (r_row == C_ROW_LAST);
  assign w_brd_last     = (r_row == C_ROW_LAST) && (r_col == C_COL_LAST);
  assign w_win_idx      = ({2'b00, r_cofs} * 4'd3) + {2'b00, r_sub};
  assign w_fetch_row    = r_row + ROW_W'(r_sub) - ROW_W'(1);
  assign w_fetch_col    = r_col + COL_W'(r_cofs) - COL_W'(1);

  // One extra bit keeps centre + tol from wrapping.
  assign w_thresh  = {1'b0, r_win[4]} + {1'b0, r_tol};
  assign w_code[0] = {1'b0, r_win[0]} >= w_thresh;
  assign w_code[1] = {1'b0, r_win[3]} >= w_thresh;
  assign w_code[2] = {1'b0, r_win[6]} >= w_thresh;
  assign w_code[3] = {1'b0, r_win[1]} >= w_thresh;
  assign w_code[4] = {1'b0, r_win[7]} >= w_thresh;
  assign w_code[5] = {1'b0, r_win[2]} >= w_thresh;
  assign w_code[6] = {1'b0, r_win[5]} >= w_thresh;
  assign w_code[7] = {1'b0, r_win[8]} >= w_thresh;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    gray_req  = 1'b0;
    gray_addr = '0;
    lbp_valid = 1'b0;
    lbp_addr  = '0;
    lbp_data  = '0;
    finish    = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_start) begin
          if (C_HAS_INT)        w_next = S_FILL;
          else if (border_mode) w_next = S_BORDER;
          else                  w_next = S_DONE;
        end
      end
      S_FILL, S_SHIFT: begin
        gray_req  = 1'b1;
        gray_addr = {w_fetch_row, w_fetch_col};
        if (w_fetch_last) w_next = S_WRITE;
      end
      S_WRITE: begin
        lbp_valid = 1'b1;
        lbp_addr  = {r_row, r_col};
        lbp_data  = w_code;
        if (lbp_ready) begin
          if (w_col_more)      w_next = S_SHIFT;
          else if (w_row_more) w_next = S_FILL;
          else if (r_border)   w_next = S_BORDER;
          else                 w_next = S_DONE;
        end
      end
      S_BORDER: begin
        lbp_valid = 1'b1;
        lbp_addr  = {r_row, r_col};
        if (lbp_ready && w_brd_last) w_next = S_DONE;
      end
      S_DONE: begin
        finish = 1'b1;
        busy   = 1'b0;
        w_next = S_IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_gray_prev <= 1'b0;
      r_row       <= '0;
      r_col       <= '0;
      r_sub       <= '0;
      r_cofs      <= '0;
      r_tol       <= '0;
      r_border    <= 1'b0;
    end else begin
      r_gray_prev <= gray_ready;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_tol    <= tol;
            r_border <= border_mode;
            r_row    <= C_HAS_INT ? ROW_W'(1) : '0;
            r_col    <= C_HAS_INT ? COL_W'(1) : '0;
            r_sub    <= '0;
            r_cofs   <= '0;
          end
        end
        S_FILL, S_SHIFT: begin
          if (r_sub == 2'd2) begin
            r_sub  <= '0;
            r_cofs <= r_cofs + 2'd1;
          end else begin
            r_sub <= r_sub + 2'd1;
          end
        end
        S_WRITE: begin
          if (w_accept) begin
            r_sub <= '0;
            if (w_col_more) begin
              r_col  <= r_col + COL_W'(1);
              r_cofs <= 2'd2;
            end else if (w_row_more) begin
              r_row  <= r_row + ROW_W'(1);
              r_col  <= COL_W'(1);
              r_cofs <= '0;
            end else begin
              r_row <= '0;
              r_col <= '0;
            end
          end
        end
        S_BORDER: begin
          // Top and bottom rows are swept fully; middle rows touch only both ends.
          if (w_accept) begin
            if (w_brd_edge_row) begin
              if (r_col == C_COL_LAST) begin
                r_row <= r_row + ROW_W'(1);
                r_col <= '0;
              end else begin
                r_col <= r_col + COL_W'(1);
              end
            end else if (r_col == '0) begin
              r_col <= C_COL_LAST;
            end else begin
              r_row <= r_row + ROW_W'(1);
              r_col <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_FILL) || (r_state == S_SHIFT)) begin
      for (int i = 0; i < 9; i++) begin
        if (w_win_idx == 4'(i)) r_win[i] <= gray_data;
      end
    end else if (w_accept && (r_state == S_WRITE) && w_col_more) begin
      for (int i = 0; i < 6; i++) r_win[i] <= r_win[i+3];
    end
  end

endmodule
`default_nettype wire
